// File: rtl/bus_rx_target.sv
`default_nettype none
// ============================================================================
//  Module   : bus_rx_target
//  Purpose  : Receiving end of the shared 2-bit arbitrated bus. Samples the
//             bus once per one-hot grant, tags the word with its source
//             master and buffers it in a small FIFO for a downstream
//             consumer. Reports back-pressure and sticky error flags.
//  Options  : BUS_RX_STATS_EN - adds per-master accepted-word counters
//             (cnt_m1, cnt_m2, cnt_m3).
//  Revision : 1.0 - initial release
// ============================================================================
module bus_rx_target #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    grant,
    input  logic [1:0]    bus_data,
    output logic          rx_ready,
    input  logic          rd_en,
    output logic [3:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic [1:0]    last_data,
    output logic          overflow,
    output logic          protocol_err
`ifdef BUS_RX_STATS_EN
    ,
    output logic [7:0]    cnt_m1,
    output logic [7:0]    cnt_m2,
    output logic [7:0]    cnt_m3
`endif
);

    localparam int           DEPTH     = 2 ** AW;
    localparam logic [AW:0]  DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      prev_grant_q, prev_grant_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [3:0]      rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic [1:0]      last_data_q, last_data_d;
    logic            overflow_q, overflow_d;
    logic            protocol_err_q, protocol_err_d;
    logic [3:0]      mem_q [DEPTH];

    logic            grant_onehot;
    logic            grant_illegal;
    logic            xfer_event;
    logic [1:0]      src_id;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;

`ifdef BUS_RX_STATS_EN
    logic [7:0]      cnt_m1_q, cnt_m1_d;
    logic [7:0]      cnt_m2_q, cnt_m2_d;
    logic [7:0]      cnt_m3_q, cnt_m3_d;
`endif

    // Grant decode, transfer detection, FIFO control and next-state logic
    always_comb begin
        grant_onehot  = (grant != 3'd0) && ((grant & (grant - 3'd1)) == 3'd0);
        grant_illegal = (grant != 3'd0) && !grant_onehot;
        // A held grant captures once; a hand-over to another master is a new
        // event. Leaving ERR with a one-hot grant always differs from the
        // illegal grant stored, so it is an event too.
        xfer_event    = grant_onehot && ((state_q == ST_IDLE) || (grant != prev_grant_q));

        case (grant)
            3'b001:  src_id = 2'd1;
            3'b010:  src_id = 2'd2;
            3'b100:  src_id = 2'd3;
            default: src_id = 2'd0;
        endcase

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_CNT);
        pop        = rd_en && !fifo_empty;
        // A full FIFO still accepts when the consumer frees a slot this cycle
        push       = xfer_event && (!fifo_full || pop);
        drop       = xfer_event && fifo_full && !pop;

        if (grant == 3'd0) begin
            state_d = ST_IDLE;
        end else if (grant_illegal) begin
            state_d = ST_ERR;
        end else begin
            state_d = ST_HELD;
        end
        prev_grant_d = grant;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end

        rd_data_d      = pop ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d     = pop;
        last_data_d    = push ? bus_data : last_data_q;
        overflow_d     = overflow_q | drop;
        protocol_err_d = protocol_err_q | grant_illegal;

`ifdef BUS_RX_STATS_EN
        cnt_m1_d = (push && src_id == 2'd1) ? cnt_m1_q + 8'd1 : cnt_m1_q;
        cnt_m2_d = (push && src_id == 2'd2) ? cnt_m2_q + 8'd1 : cnt_m2_q;
        cnt_m3_d = (push && src_id == 2'd3) ? cnt_m3_q + 8'd1 : cnt_m3_q;
`endif
    end

    // Control, status and read-port registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            prev_grant_q   <= 3'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rd_data_q      <= 4'd0;
            rd_valid_q     <= 1'b0;
            last_data_q    <= 2'd0;
            overflow_q     <= 1'b0;
            protocol_err_q <= 1'b0;
`ifdef BUS_RX_STATS_EN
            cnt_m1_q       <= 8'd0;
            cnt_m2_q       <= 8'd0;
            cnt_m3_q       <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            prev_grant_q   <= prev_grant_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            last_data_q    <= last_data_d;
            overflow_q     <= overflow_d;
            protocol_err_q <= protocol_err_d;
`ifdef BUS_RX_STATS_EN
            cnt_m1_q       <= cnt_m1_d;
            cnt_m2_q       <= cnt_m2_d;
            cnt_m3_q       <= cnt_m3_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care after reset since pointers clear
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= {src_id, bus_data};
        end
    end

    assign rx_ready     = !fifo_full;
    assign empty        = fifo_empty;
    assign full         = fifo_full;
    assign count        = count_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign last_data    = last_data_q;
    assign overflow     = overflow_q;
    assign protocol_err = protocol_err_q;
`ifdef BUS_RX_STATS_EN
    assign cnt_m1       = cnt_m1_q;
    assign cnt_m2       = cnt_m2_q;
    assign cnt_m3       = cnt_m3_q;
`endif

endmodule
`default_nettype wire
